// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, IF/ID
// update selector and reset defaults.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DROP  = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_KEEP   = 2'b00,
    IFID_FETCH  = 2'b01,
    IFID_BUF    = 2'b10,
    IFID_BUBBLE = 2'b11
  } ifid_op_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that IF/ID could not accept.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= 32'h0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, branch
// redirect with in-flight response dropping, and a skid buffer for stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PC_EN_IF,
  input  logic         reg_FD_EN,
  input  logic         reg_FD_stall,
  input  logic         reg_FD_flush,
  input  logic         Branch_ID,
  input  logic [31:0]  branch_target_ID,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  PC_ID,
  output logic [31:0]  inst_ID,
  output logic         valid_ID,
  output logic         fetch_busy,
  output fetch_state_e state_dbg
);

  // Memory handshake: a request is live while imem_req=1 and imem_addr is held
  // until the cycle imem_ack=1 (possibly the request cycle itself); that cycle
  // completes it, and only one request is ever outstanding.

  fetch_state_e state, state_nxt;
  ifid_op_e     ifid_op;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  drop_addr, drop_nxt;
  logic         hold, redirect;
  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_pc, buf_inst;
  logic [31:0]  target;

  assign hold     = reg_FD_stall | ~PC_EN_IF | ~reg_FD_EN;
  assign redirect = Branch_ID & ~hold;
  assign target   = word_align(branch_target_ID);

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pc),
    .load_inst (imem_rdata),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop_addr;
    ifid_op   = IFID_KEEP;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          pc_nxt  = target;
          ifid_op = IFID_BUBBLE;
          if (!imem_ack) begin
            drop_nxt  = pc;
            state_nxt = ST_DROP;
          end
        end else if (imem_ack) begin
          pc_nxt = pc + 32'd4;
          if (hold) begin
            buf_load  = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ifid_op = reg_FD_flush ? IFID_BUBBLE : IFID_FETCH;
          end
        end else if (!hold) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          buf_clear = 1'b1;
          ifid_op   = IFID_BUBBLE;
          state_nxt = ST_FETCH;
        end else if (!hold) begin
          buf_clear = 1'b1;
          ifid_op   = reg_FD_flush ? IFID_BUBBLE : IFID_BUF;
          state_nxt = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The stale response still has to be absorbed before a new request.
        if (redirect) pc_nxt = target;
        if (imem_ack) state_nxt = ST_FETCH;
        if (!hold) ifid_op = IFID_BUBBLE;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = ~rst & (state != ST_HOLD);
    imem_addr  = (state == ST_DROP) ? drop_addr : pc;
    fetch_busy = (state != ST_FETCH);
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      PC_ID     <= 32'h0;
      inst_ID   <= NOP_INST;
      valid_ID  <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      drop_addr <= drop_nxt;
      case (ifid_op)
        IFID_FETCH: begin
          PC_ID    <= pc;
          inst_ID  <= imem_rdata;
          valid_ID <= 1'b1;
        end
        IFID_BUF: begin
          PC_ID    <= buf_pc;
          inst_ID  <= buf_inst;
          valid_ID <= buf_valid;
        end
        IFID_BUBBLE: begin
          PC_ID    <= 32'h0;
          inst_ID  <= NOP_INST;
          valid_ID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, IF/ID consumer
// scoreboard and directed scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         PC_EN_IF = 1'b1;
  logic         reg_FD_EN = 1'b1;
  logic         reg_FD_stall = 1'b0;
  logic         reg_FD_flush = 1'b0;
  logic         Branch_ID = 1'b0;
  logic [31:0]  branch_target_ID = 32'h0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic [31:0]  PC_ID, inst_ID;
  logic         valid_ID, fetch_busy;
  fetch_state_e state_dbg;

  logic         imem_req2, imem_ack2, valid_ID2, fetch_busy2;
  logic [31:0]  imem_addr2, imem_rdata2, PC_ID2, inst_ID2;
  fetch_state_e state_dbg2;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush),
    .Branch_ID(Branch_ID), .branch_target_ID(branch_target_ID),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC_ID(PC_ID), .inst_ID(inst_ID),
    .valid_ID(valid_ID), .fetch_busy(fetch_busy), .state_dbg(state_dbg)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush),
    .Branch_ID(Branch_ID), .branch_target_ID(branch_target_ID),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_rdata(imem_rdata2), .PC_ID(PC_ID2), .inst_ID(inst_ID2),
    .valid_ID(valid_ID2), .fetch_busy(fetch_busy2), .state_dbg(state_dbg2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Zero-wait memory for the wrap instance
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = inst_of(imem_addr2);

  // Memory model: acks after mem_lat wait cycles
  always begin
    @(negedge clk);
    #1;
    if (rst || !imem_req) imem_ack = 1'b0;
    else                  imem_ack = (wait_cnt >= mem_lat);
    imem_rdata = imem_ack ? inst_of(imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard: ID consumes IF/ID on every unheld edge with valid_ID=1
  always begin
    logic [63:0] exp;
    @(negedge clk);
    #2;
    if (!rst && valid_ID && !(reg_FD_stall | ~PC_EN_IF | ~reg_FD_EN)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL consume: got PC_ID=%h inst_ID=%h, expected no instruction", PC_ID, inst_ID);
      end else begin
        exp = exp_q.pop_front();
        if ({PC_ID, inst_ID} !== exp) begin
          errors++;
          $display("FAIL consume: got PC_ID=%h inst_ID=%h, expected PC_ID=%h inst_ID=%h",
                   PC_ID, inst_ID, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, inst_of(pc)});
  endtask

  task automatic drive(input logic stall, input logic pc_en, input logic fd_en,
                       input logic flush, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst              = 1'b0;
    reg_FD_stall     = stall;
    PC_EN_IF         = pc_en;
    reg_FD_EN        = fd_en;
    reg_FD_flush     = flush;
    Branch_ID        = br;
    branch_target_ID = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic stall_end();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst = 1'b1;
    mem_lat = lat;
    reg_FD_stall = 1'b0; PC_EN_IF = 1'b1; reg_FD_EN = 1'b1;
    reg_FD_flush = 1'b0; Branch_ID = 1'b0; branch_target_ID = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_lat = 0;
    #2;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", imem_req); end
    @(negedge clk);
    #2;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req2: got %b, expected 0", imem_req); end
    checks++;
    if ({valid_ID, PC_ID, inst_ID} !== {1'b0, 32'h0, 32'h0000_0013}) begin
      errors++; $display("FAIL reset_ifid: got %b/%h/%h, expected 0/0/00000013", valid_ID, PC_ID, inst_ID);
    end
    checks++;
    if (fetch_busy !== 1'b0 || state_dbg !== ST_FETCH) begin
      errors++; $display("FAIL reset_state: got busy=%b state=%0d, expected 0/FETCH", fetch_busy, state_dbg);
    end
    idle();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
    stall_end();
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    idle();
    #2;
    checks++;
    if (valid_ID !== 1'b0) begin errors++; $display("FAIL zw_first: got valid %b, expected 0", valid_ID); end
    for (int i = 0; i < 4; i++) begin
      idle();
      #2;
      checks++;
      if (valid_ID !== 1'b1 || PC_ID !== 32'(i * 4)) begin
        errors++; $display("FAIL zw_seq: got valid=%b PC_ID=%h, expected 1/%h", valid_ID, PC_ID, 32'(i * 4));
      end
    end
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL zw_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    idle(); idle();
    stall_end();
    #2;
    checks++;
    if (PC_ID !== 32'h4) begin errors++; $display("FAIL st_hold0: got PC_ID %h, expected 4", PC_ID); end
    stall_end();
    #2;
    checks++;
    if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || state_dbg !== ST_HOLD || PC_ID !== 32'h4) begin
      errors++; $display("FAIL st_hold1: got busy=%b req=%b state=%0d PC_ID=%h, expected 1/0/HOLD/4",
                         fetch_busy, imem_req, state_dbg, PC_ID);
    end
    idle();
    #2;
    checks++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b1 || PC_ID !== 32'h4) begin
      errors++; $display("FAIL st_release: got req=%b busy=%b PC_ID=%h, expected 0/1/4", imem_req, fetch_busy, PC_ID);
    end
    idle();
    #2;
    checks++;
    if (PC_ID !== 32'h8 || fetch_busy !== 1'b0 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL st_buf: got PC_ID=%h busy=%b addr=%h, expected 8/0/c", PC_ID, fetch_busy, imem_addr);
    end
    idle();
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL st_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_branch_latency();
    do_reset(3);
    push_exp(32'h100);
    idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    idle();
    #2;
    checks++;
    if (state_dbg !== ST_DROP || imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_busy !== 1'b1) begin
      errors++; $display("FAIL br_drop: got state=%0d req=%b addr=%h busy=%b, expected DROP/1/0/1",
                         state_dbg, imem_req, imem_addr, fetch_busy);
    end
    idle();
    idle();
    #2;
    checks++;
    if (state_dbg !== ST_FETCH || imem_addr !== 32'h100) begin
      errors++; $display("FAIL br_newreq: got state=%0d addr=%h, expected FETCH/100", state_dbg, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      #2;
      checks++;
      if (valid_ID !== 1'b0) begin errors++; $display("FAIL br_bubble: got valid %b, expected 0", valid_ID); end
    end
    idle();
    #2;
    checks++;
    if (valid_ID !== 1'b1 || PC_ID !== 32'h100) begin
      errors++; $display("FAIL br_target: got valid=%b PC_ID=%h, expected 1/100", valid_ID, PC_ID);
    end
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL br_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h300);
    idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h303);
    idle();
    #2;
    checks++;
    if (valid_ID !== 1'b0 || inst_ID !== 32'h13 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL rd_bubble: got valid=%b inst=%h addr=%h, expected 0/13/300", valid_ID, inst_ID, imem_addr);
    end
    idle();
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_branch_stall();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    idle(); idle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    idle();
    #2;
    checks++;
    if (state_dbg !== ST_HOLD || PC_ID !== 32'h4) begin
      errors++; $display("FAIL bs_held: got state=%0d PC_ID=%h, expected HOLD/4", state_dbg, PC_ID);
    end
    idle();
    #2;
    checks++;
    if (imem_addr !== 32'hC || PC_ID !== 32'h8) begin
      errors++; $display("FAIL bs_noredir: got addr=%h PC_ID=%h, expected c/8", imem_addr, PC_ID);
    end
    idle();
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bs_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h4);
    idle(); idle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    stall_end();
    #2;
    checks++;
    if ({valid_ID, PC_ID, inst_ID} !== {1'b0, 32'h0, 32'h0000_0013}) begin
      errors++; $display("FAIL flush: got %b/%h/%h, expected 0/0/00000013", valid_ID, PC_ID, inst_ID);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fl_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_in_hold();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h0);
    idle(); idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    checks++;
    if (state_dbg !== ST_HOLD || fetch_busy !== 1'b1) begin
      errors++; $display("FAIL rh_hold: got state=%0d busy=%b, expected HOLD/1", state_dbg, fetch_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_req: got %b, expected 0", imem_req); end
    idle();
    #2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_ID !== 1'b0 || inst_ID !== 32'h13 ||
        state_dbg !== ST_FETCH || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL rh_fresh: got req=%b addr=%h valid=%b inst=%h state=%0d, expected 1/0/0/13/FETCH",
                         imem_req, imem_addr, valid_ID, inst_ID, state_dbg);
    end
    idle();
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rh_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    push_exp(32'h0); push_exp(32'h4);
    idle();
    #2;
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: got req=%b addr=%h, expected 1/fffffffc", imem_req2, imem_addr2);
    end
    idle();
    #2;
    checks++;
    if (imem_addr2 !== 32'h0 || PC_ID2 !== 32'hFFFF_FFFC || valid_ID2 !== 1'b1) begin
      errors++; $display("FAIL wrap_second: got addr=%h PC_ID=%h valid=%b, expected 0/fffffffc/1",
                         imem_addr2, PC_ID2, valid_ID2);
    end
    idle();
    #2;
    checks++;
    if (PC_ID2 !== 32'h0 || inst_ID2 !== inst_of(32'h0) || state_dbg2 !== ST_FETCH) begin
      errors++; $display("FAIL wrap_id: got PC_ID=%h inst=%h state=%0d, expected 0/%h/FETCH",
                         PC_ID2, inst_ID2, state_dbg2, inst_of(32'h0));
    end
    stall_end();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch_latency();
    test_redirect_ack();
    test_branch_stall();
    test_flush();
    test_reset_in_hold();
    test_wrap();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the bubble instruction (addi x0,x0,0).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 PC_EN_IF  in  1  hazard unit PC enable; 0 = hold PC.
REQ-006 reg_FD_EN  in  1  IF/ID register enable; 0 = hold everything.
REQ-007 reg_FD_stall  in  1  load-use stall; hold IF/ID contents.
REQ-008 reg_FD_flush  in  1  replace IF/ID contents with a bubble.
REQ-009 Branch_ID  in  1  taken branch/jump resolved in ID.
REQ-010 branch_target_ID  in  32  redirect address, valid with Branch_ID.
REQ-011 imem_req  out  1  instruction memory request.
REQ-012 imem_addr  out  32  request address; stable while imem_req=1 until imem_ack.
REQ-013 imem_ack  in  1  response valid this cycle; may assert in the request cycle (zero wait) or later.
REQ-014 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-015 PC_ID / inst_ID / valid_ID  out  32/32/1  IF/ID register contents.
REQ-016 fetch_busy  out  1  high when state != FETCH.

Function
REQ-017 Stall condition hold = reg_FD_stall | ~PC_EN_IF | ~reg_FD_EN; redirect = Branch_ID & ~hold (stall outranks branch).
REQ-018 States: FETCH (imem_req=1, imem_addr=pc), HOLD (imem_req=0, skid buffer full), DROP (imem_req=1, imem_addr=drop_addr, response discarded).
REQ-019 FETCH, ack, ~hold, ~redirect: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay FETCH.
REQ-020 FETCH, ack, hold: buffer <= {pc, imem_rdata}; pc <= pc+4; IF/ID held; go to HOLD.
REQ-021 FETCH, no ack, ~redirect: IF/ID <= bubble unless hold, in which case IF/ID is held.
REQ-022 FETCH, redirect, ack: response dropped; pc <= branch_target_ID; stay FETCH.
REQ-023 FETCH, redirect, no ack: drop_addr <= pc; pc <= branch_target_ID; go to DROP.
REQ-024 HOLD, hold: no change. HOLD, ~hold, ~redirect: IF/ID <= {buffer, 1}; go to FETCH.
REQ-025 HOLD, redirect: buffer discarded; pc <= branch_target_ID; go to FETCH.
REQ-026 DROP, ack: response discarded; go to FETCH. DROP, redirect: pc <= branch_target_ID; stay DROP.
REQ-027 Any redirect or reg_FD_flush (without hold) loads an IF/ID bubble: PC_ID=0, inst_ID=NOP_INST, valid_ID=0.
REQ-028 pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. branch_target_ID[1:0] is forced to 0.
REQ-029 Only one request is outstanding at a time. At most one response is stored in the buffer.

Reset
REQ-030 While rst=1: imem_req=0. On the next edge: state=FETCH, pc=RESET_PC, buffer empty, IF/ID bubble.
REQ-031 Reset mid-request abandons the request with no drop. The memory shares rst and cancels it.
REQ-032 The first request (addr=RESET_PC) issues in the first cycle with rst=0.

Structure
REQ-033 The shared package holds the state encoding (FETCH=2'b00, HOLD=2'b01, DROP=2'b10), NOP_INST, and the default RESET_PC.
REQ-034 The one-entry skid buffer is sub-module fetch_skid_buf (load, clear, valid, pc, inst). The FSM and IF/ID register stay in fetch_unit.

Verification
REQ-035 Zero-wait memory, no hazards, 4 cycles after reset: PC_ID = 0, 4, 8, 12, each with valid_ID=1.
REQ-036 Ack arrives with reg_FD_stall=1 for 2 cycles: fetch_busy=1 and imem_req=0 during the stall. The buffered word enters IF/ID on the first unstalled cycle. No instruction is lost or duplicated.
REQ-037 Memory latency 3, Branch_ID=1 with target 0x100 in wait cycle 1: the old response is discarded (DROP), the next request has addr=0x100, and valid_ID=0 until 0x100 arrives.
REQ-038 Branch_ID=1 and reg_FD_stall=1 together: redirect is ignored, pc is unchanged, and IF/ID is held.
REQ-039 RESET_PC=32'hFFFF_FFFC, zero wait: the second request has addr=0.
REQ-040 rst asserted while in HOLD with a full buffer: imem_req=0 during reset, then a fresh fetch from RESET_PC with an IF/ID bubble.
